// File: rtl/mode_reporter.sv
// mode_reporter: UART 8N1 transmitter that reports the active waveform mode
// to the host as "<char>\r\n" on every mode change or query pulse.
module mode_reporter #(
  parameter int unsigned CLK_FREQ     = 12_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       query,
  output logic       tx,
  output logic       busy,
  output logic       msg_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] RESET_MODE = 3'b001;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [1:0] LAST_IDX   = 2'd2;
  localparam logic [2:0] LAST_BIT   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [1:0]       idx_q;
  logic [7:0]       shift_q;
  logic             pending_q;
  logic [2:0]       prev_mode_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic             event_c;
  logic             bit_end_c;
  logic [7:0]       char_c;
  logic [7:0]       next_byte_d;
  logic [1:0]       next_idx_d;

  // ASCII encoding of the mode value
  function automatic logic [7:0] encode_mode(input logic [2:0] m);
    case (m)
      3'b001:  return 8'h41;
      3'b010:  return 8'h42;
      default: return 8'h3F;
    endcase
  endfunction

  // Event detect, bit boundary and byte source for the following frame
  always_comb begin
    event_c     = query | (mode != prev_mode_q);
    bit_end_c   = (baud_q == CNT_LAST);
    char_c      = encode_mode(mode);
    next_idx_d  = 2'(idx_q + 2'd1);
    next_byte_d = (idx_q == 2'd0) ? CHAR_CR : CHAR_LF;
  end

  // Transmit FSM with pending-event capture and registered line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      pending_q   <= 1'b0;
      prev_mode_q <= RESET_MODE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      prev_mode_q <= mode;
      done_q      <= 1'b0;

      // Events during a message collapse into one sticky request
      if (state_q != S_IDLE && event_c) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          if (event_c || pending_q) begin
            shift_q   <= char_c;
            idx_q     <= 2'd0;
            bit_q     <= 3'd0;
            pending_q <= 1'b0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_START;
          end
        end

        S_START: begin
          if (bit_end_c) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= 3'd0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (bit_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= 3'(bit_q + 3'd1);
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (idx_q != LAST_IDX) begin
              // Next byte follows straight on, no idle gap
              idx_q   <= next_idx_d;
              shift_q <= next_byte_d;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign msg_done = done_q;

endmodule

// File: tb/tb_mode_reporter.sv
// Directed bench for mode_reporter at 10 clocks per bit.
module tb_mode_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       query;
  logic       tx;
  logic       busy;
  logic       msg_done;

  int passed = 0;
  int total  = 0;

  logic tx_cap   [0:799];
  logic busy_cap [0:799];
  logic done_cap [0:799];

  mode_reporter #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .query   (query),
    .tx      (tx),
    .busy    (busy),
    .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int i);
    tx_cap[i]   = tx;
    busy_cap[i] = busy;
    done_cap[i] = msg_done;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reads the data byte of a frame whose start bit begins at index base
  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = tx_cap[base + 10 * (j + 1) + 5];
    return b;
  endfunction

  // Expected line level at offset i of a message whose first byte is b0
  function automatic logic exp_line(input logic [7:0] b0, input int i);
    int k;
    int j;
    logic [7:0] b;
    k = i / 100;
    j = (i % 100) / 10;
    b = (k == 0) ? b0 : ((k == 1) ? 8'h0D : 8'h0A);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j - 1];
  endfunction

  function automatic int count_high(input int sel, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) begin
      if (sel == 0 && tx_cap[i] === 1'b1) n++;
      if (sel == 1 && busy_cap[i] === 1'b1) n++;
      if (sel == 2 && done_cap[i] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    int tx_low;
    int busy_hi;
    int done_hi;
    rst = 1'b0; mode = 3'b001; query = 1'b0;
    #1 rst = 1'b1;
    #2;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || msg_done !== 1'b0)
      $display("FAIL reset_values: got tx=%b busy=%b done=%b need 1 0 0", tx, busy, msg_done);
    else passed++;
    step(); step();
    rst = 1'b0;
    tx_low = 0; busy_hi = 0; done_hi = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (tx !== 1'b1) tx_low++;
      if (busy !== 1'b0) busy_hi++;
      if (msg_done !== 1'b0) done_hi++;
    end
    total++;
    if (tx_low != 0 || busy_hi != 0 || done_hi != 0)
      $display("FAIL reset_quiet: got tx_low=%0d busy=%0d done=%0d need 0 0 0", tx_low, busy_hi, done_hi);
    else passed++;
  endtask

  task automatic test_mode_change();
    mode = 3'b010;
    for (int i = 0; i < 310; i++) begin step(); sample(i); end
    total++;
    if (tx_cap[0] !== 1'b0) $display("FAIL change_latency: got tx=%b need 0", tx_cap[0]);
    else passed++;
    total++;
    if (decode(0) !== 8'h42) $display("FAIL change_byte0: got %h need 42", decode(0));
    else passed++;
    total++;
    if (decode(100) !== 8'h0D) $display("FAIL change_byte1: got %h need 0d", decode(100));
    else passed++;
    total++;
    if (decode(200) !== 8'h0A) $display("FAIL change_byte2: got %h need 0a", decode(200));
    else passed++;
    total++;
    if (count_high(1, 0, 309) != 300 || busy_cap[300] !== 1'b0)
      $display("FAIL change_busy: got %0d cycles need 300", count_high(1, 0, 309));
    else passed++;
    total++;
    if (count_high(2, 0, 309) != 1 || done_cap[300] !== 1'b1)
      $display("FAIL change_done: got count=%0d at300=%b need 1 1", count_high(2, 0, 309), done_cap[300]);
    else passed++;
  endtask

  task automatic test_query();
    int errs;
    mode = 3'b001;
    idle(320);
    query = 1'b1;
    for (int i = 0; i < 310; i++) begin step(); query = 1'b0; sample(i); end
    errs = 0;
    for (int i = 0; i < 300; i++) if (tx_cap[i] !== exp_line(8'h41, i)) errs++;
    total++;
    if (errs != 0) $display("FAIL query_waveform: got %0d bad cycles need 0", errs);
    else passed++;
    total++;
    if (decode(0) !== 8'h41 || decode(100) !== 8'h0D || decode(200) !== 8'h0A)
      $display("FAIL query_bytes: got %h %h %h need 41 0d 0a", decode(0), decode(100), decode(200));
    else passed++;
    total++;
    if (count_high(0, 300, 309) != 10) $display("FAIL query_idle_after: got %0d high need 10", count_high(0, 300, 309));
    else passed++;
  endtask

  task automatic test_unknown();
    mode = 3'b000;
    for (int i = 0; i < 310; i++) begin step(); sample(i); end
    total++;
    if (decode(0) !== 8'h3F) $display("FAIL unknown_000: got %h need 3f", decode(0));
    else passed++;
    mode = 3'b111;
    idle(320);
    query = 1'b1;
    for (int i = 0; i < 310; i++) begin step(); query = 1'b0; sample(i); end
    total++;
    if (decode(0) !== 8'h3F) $display("FAIL unknown_111: got %h need 3f", decode(0));
    else passed++;
  endtask

  task automatic test_back_to_back();
    mode = 3'b010;
    idle(320);
    query = 1'b1;
    for (int i = 0; i < 700; i++) begin
      step();
      sample(i);
      query = (i == 100 || i == 150 || i == 200);
      if (i == 50) mode = 3'b001;
    end
    total++;
    if (decode(0) !== 8'h42 || decode(100) !== 8'h0D || decode(200) !== 8'h0A)
      $display("FAIL b2b_first: got %h %h %h need 42 0d 0a", decode(0), decode(100), decode(200));
    else passed++;
    total++;
    if (busy_cap[299] !== 1'b1 || busy_cap[300] !== 1'b0 || tx_cap[300] !== 1'b1 || tx_cap[301] !== 1'b0)
      $display("FAIL b2b_gap: got busy=%b%b tx=%b%b need 10 10", busy_cap[299], busy_cap[300], tx_cap[300], tx_cap[301]);
    else passed++;
    total++;
    if (decode(301) !== 8'h41 || decode(401) !== 8'h0D || decode(501) !== 8'h0A)
      $display("FAIL b2b_second: got %h %h %h need 41 0d 0a", decode(301), decode(401), decode(501));
    else passed++;
    total++;
    if (count_high(2, 0, 699) != 2 || done_cap[601] !== 1'b1)
      $display("FAIL b2b_done: got count=%0d at601=%b need 2 1", count_high(2, 0, 699), done_cap[601]);
    else passed++;
    total++;
    if (count_high(0, 602, 699) != 98 || count_high(1, 602, 699) != 0)
      $display("FAIL b2b_no_third: got tx_high=%0d busy=%0d need 98 0", count_high(0, 602, 699), count_high(1, 602, 699));
    else passed++;
  endtask

  task automatic test_simultaneous();
    query = 1'b1;
    for (int i = 0; i < 420; i++) begin
      step();
      sample(i);
      query = (i == 299);
    end
    total++;
    if (done_cap[300] !== 1'b1 || tx_cap[300] !== 1'b1 || tx_cap[301] !== 1'b0)
      $display("FAIL simul_restart: got done=%b tx=%b%b need 1 10", done_cap[300], tx_cap[300], tx_cap[301]);
    else passed++;
    total++;
    if (decode(301) !== 8'h41) $display("FAIL simul_byte0: got %h need 41", decode(301));
    else passed++;
    idle(250);
  endtask

  task automatic test_reset_mid();
    int act;
    mode = 3'b001;
    query = 1'b1;
    for (int i = 0; i <= 150; i++) begin step(); query = 1'b0; sample(i); end
    total++;
    if (tx_cap[150] !== 1'b0 || busy_cap[150] !== 1'b1)
      $display("FAIL midreset_pre: got tx=%b busy=%b need 0 1", tx_cap[150], busy_cap[150]);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL midreset_async: got tx=%b busy=%b need 1 0", tx, busy);
    else passed++;
    step(); step();
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || msg_done !== 1'b0) act++;
    end
    total++;
    if (act != 0) $display("FAIL midreset_quiet: got %0d active cycles need 0", act);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mode_change();
    test_query();
    test_unknown();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
